// File: rtl/axi_rd_latency_mon.sv
// AXI read latency monitor.
// Timestamps each tracked read-address handshake per ID and, when the last
// read beat of that ID arrives, emits the elapsed cycle count as a sample.
// Also keeps running count, saturating total, min and max, plus sticky
// protocol error flags.
//
// Event inputs are single-cycle qualified pulses: tt_arvalid means
// arvalid && arready in this cycle, tt_rlast means rvalid && rready && rlast
// in this cycle. There is no backpressure; every pulse is consumed in the
// cycle it is presented.
//
// The latency is computed in the rlast cycle and registered together with
// all statistics, so lat_valid and the updated statistics appear on the
// same cycle. Since the sample pipeline is a single register stage, a clear
// in the rlast cycle drops that rlast outright. A sample already registered
// still pulses lat_valid, and the statistics it carried are already in
// place, so nothing later can alter them.
//
// TS_WIDTH is expected to be at most 48 so a latency fits the total adder.
module axi_rd_latency_mon #(
  parameter int ID_WIDTH = 5,
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                tt_arvalid,
  input  logic [ID_WIDTH-1:0] tt_arid,
  input  logic                tt_rlast,
  input  logic [ID_WIDTH-1:0] tt_rid,
  output logic                lat_valid,
  output logic [TS_WIDTH-1:0] lat_value,
  output logic [31:0]         lat_count,
  output logic [47:0]         lat_total,
  output logic [TS_WIDTH-1:0] lat_min,
  output logic [TS_WIDTH-1:0] lat_max,
  output logic [ID_WIDTH:0]   outstanding,
  output logic                err_dup_id,
  output logic                err_orphan
);

  localparam int NUM_IDS = 1 << ID_WIDTH;

  logic [TS_WIDTH-1:0] ts_q;
  logic [NUM_IDS-1:0]  valid_q;
  logic [NUM_IDS-1:0]  valid_d;
  logic [TS_WIDTH-1:0] ts_mem [NUM_IDS];

  logic                take_r;
  logic                take_a;
  logic                hit;
  logic                orphan;
  logic                dup;
  logic [TS_WIDTH-1:0] lat;
  logic [48:0]         sum;
  logic [ID_WIDTH:0]   pop;

  logic [31:0]         count_q;
  logic [47:0]         total_q;
  logic [TS_WIDTH-1:0] min_q;
  logic [TS_WIDTH-1:0] max_q;

  assign lat_count = count_q;
  assign lat_total = total_q;
  assign lat_min   = min_q;
  assign lat_max   = max_q;

  // Event qualification, next valid table, latency and saturating sum.
  always_comb begin
    take_r  = tt_rlast & ~clear;
    take_a  = tt_arvalid & enable & ~clear;
    hit     = take_r & valid_q[tt_rid];
    orphan  = take_r & ~valid_q[tt_rid];
    // A retire on the same ID in the same cycle frees the slot first, so
    // the re-open is legitimate and not a duplicate.
    dup     = take_a & valid_q[tt_arid] & ~(hit && (tt_rid == tt_arid));
    lat     = ts_q - ts_mem[tt_rid];
    sum     = {1'b0, total_q} + 49'(lat);
    valid_d = valid_q;
    if (hit) begin
      valid_d[tt_rid] = 1'b0;
    end
    if (take_a) begin
      valid_d[tt_arid] = 1'b1;
    end
    if (clear) begin
      valid_d = '0;
    end
    pop = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      pop = pop + (ID_WIDTH+1)'(valid_d[i]);
    end
  end

  // Free-running timestamp; clear deliberately leaves it running.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  // Per-ID start timestamps; contents only matter while the valid bit is set.
  always_ff @(posedge clk) begin
    if (take_a) begin
      ts_mem[tt_arid] <= ts_q;
    end
  end

  // Valid table and its registered population count.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      outstanding <= '0;
    end else begin
      valid_q     <= valid_d;
      outstanding <= pop;
    end
  end

  // Sample output and statistics, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_valid <= 1'b0;
      lat_value <= '0;
      count_q   <= '0;
      total_q   <= '0;
      min_q     <= '1;
      max_q     <= '0;
    end else begin
      lat_valid <= hit;
      if (hit) begin
        lat_value <= lat;
      end
      if (clear) begin
        count_q <= '0;
        total_q <= '0;
        min_q   <= '1;
        max_q   <= '0;
      end else if (hit) begin
        if (count_q != 32'hFFFF_FFFF) begin
          count_q <= count_q + 32'd1;
        end
        total_q <= sum[48] ? 48'hFFFF_FFFF_FFFF : sum[47:0];
        if (lat < min_q) begin
          min_q <= lat;
        end
        if (lat > max_q) begin
          max_q <= lat;
        end
      end
    end
  end

  // Sticky protocol error flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_dup_id <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (dup) begin
        err_dup_id <= 1'b1;
      end
      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_latency_mon.sv
// Bench for axi_rd_latency_mon: a vector table of single-cycle events with
// hand-computed outputs, followed by hand-written multi-cycle sequences.
module tb_axi_rd_latency_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        tt_arvalid;
  logic [4:0]  tt_arid;
  logic        tt_rlast;
  logic [4:0]  tt_rid;
  logic        lat_valid;
  logic [31:0] lat_value;
  logic [31:0] lat_count;
  logic [47:0] lat_total;
  logic [31:0] lat_min;
  logic [31:0] lat_max;
  logic [5:0]  outstanding;
  logic        err_dup_id;
  logic        err_orphan;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

  axi_rd_latency_mon #(.ID_WIDTH(5), .TS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .tt_arvalid(tt_arvalid), .tt_arid(tt_arid),
    .tt_rlast(tt_rlast), .tt_rid(tt_rid),
    .lat_valid(lat_valid), .lat_value(lat_value), .lat_count(lat_count),
    .lat_total(lat_total), .lat_min(lat_min), .lat_max(lat_max),
    .outstanding(outstanding), .err_dup_id(err_dup_id), .err_orphan(err_orphan)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        ar;
    logic [4:0]  arid;
    logic        rl;
    logic [4:0]  rid;
    logic        en;
    logic        clr;
    logic        lv;
    logic [31:0] lval;
    logic [5:0]  outs;
    logic        dup;
    logic        orph;
    logic [31:0] cnt;
    logic [47:0] tot;
    logic [31:0] mn;
    logic [31:0] mx;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ar, input logic [4:0] arid,
                       input logic rl, input logic [4:0] rid,
                       input logic en, input logic clr);
    tt_arvalid = ar;
    tt_arid    = arid;
    tt_rlast   = rl;
    tt_rid     = rid;
    enable     = en;
    clear      = clr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    idle();
  endtask

  initial begin
    // Vector table: each row is one cycle of input, expected outputs are
    // those visible right after that cycle's clock edge.
    //            ar arid rl rid en clr  lv lval outs dup orph cnt tot min     max
    tbl[0]  = '{1, 1,  0, 0, 1, 0,  0, 0,  1,   0,  0,   0,  0,  ONES32, 0};
    tbl[1]  = '{1, 2,  0, 0, 1, 0,  0, 0,  2,   0,  0,   0,  0,  ONES32, 0};
    tbl[2]  = '{0, 0,  0, 0, 1, 0,  0, 0,  2,   0,  0,   0,  0,  ONES32, 0};
    tbl[3]  = '{0, 0,  1, 1, 1, 0,  1, 3,  1,   0,  0,   1,  3,  3,      3};
    tbl[4]  = '{1, 2,  0, 0, 1, 0,  0, 3,  1,   1,  0,   1,  3,  3,      3};
    tbl[5]  = '{1, 4,  0, 0, 0, 0,  0, 3,  1,   1,  0,   1,  3,  3,      3};
    tbl[6]  = '{0, 0,  1, 4, 1, 0,  0, 3,  1,   1,  1,   1,  3,  3,      3};
    tbl[7]  = '{1, 2,  1, 2, 1, 0,  1, 3,  1,   1,  1,   2,  6,  3,      3};
    tbl[8]  = '{1, 5,  1, 2, 1, 0,  1, 1,  1,   1,  1,   3,  7,  1,      3};
    tbl[9]  = '{0, 0,  1, 5, 0, 0,  1, 1,  0,   1,  1,   4,  8,  1,      3};
    tbl[10] = '{1, 6,  1, 5, 1, 1,  0, 1,  0,   0,  0,   0,  0,  ONES32, 0};
    tbl[11] = '{0, 0,  1, 6, 1, 0,  0, 1,  0,   0,  1,   0,  0,  ONES32, 0};

    // Reset.
    rst = 1'b1;
    idle();
    repeat (3) tick();
    chk("rst_lat_valid", lat_valid, 0);
    chk("rst_lat_value", lat_value, 0);
    chk("rst_count", lat_count, 0);
    chk("rst_total", lat_total, 0);
    chk("rst_min", lat_min, ONES32);
    chk("rst_max", lat_max, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_dup", err_dup_id, 0);
    chk("rst_orphan", err_orphan, 0);
    chk("rst_ts", dut.ts_q, 0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ar, tbl[i].arid, tbl[i].rl, tbl[i].rid, tbl[i].en, tbl[i].clr);
      tick();
      chk($sformatf("v%0d_lat_valid", i), lat_valid, tbl[i].lv);
      chk($sformatf("v%0d_lat_value", i), lat_value, tbl[i].lval);
      chk($sformatf("v%0d_outstanding", i), outstanding, tbl[i].outs);
      chk($sformatf("v%0d_dup", i), err_dup_id, tbl[i].dup);
      chk($sformatf("v%0d_orphan", i), err_orphan, tbl[i].orph);
      chk($sformatf("v%0d_count", i), lat_count, tbl[i].cnt);
      chk($sformatf("v%0d_total", i), lat_total, tbl[i].tot);
      chk($sformatf("v%0d_min", i), lat_min, tbl[i].mn);
      chk($sformatf("v%0d_max", i), lat_max, tbl[i].mx);
    end
    idle();

    // Worked example: ID 3 address, rlast 15 cycles later.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (9) tick();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    repeat (14) tick();
    chk("ex_pre_lat_valid", lat_valid, 0);
    drive(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    chk("ex_lat_valid", lat_valid, 1);
    chk("ex_lat_value", lat_value, 15);
    chk("ex_count", lat_count, 1);
    chk("ex_min", lat_min, 15);
    chk("ex_max", lat_max, 15);
    chk("ex_total", lat_total, 15);
    tick();
    chk("ex_pulse_end", lat_valid, 0);

    // All 32 IDs open back-to-back, retired in reverse order.
    do_clear();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
    end
    chk("fill_outstanding", outstanding, 32);
    for (int j = 0; j < 32; j++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(31 - j), 1'b1, 1'b0);
      tick();
      chk($sformatf("drain%0d_lat_valid", j), lat_valid, 1);
      chk($sformatf("drain%0d_lat_value", j), lat_value, 32'(1 + 2 * j));
    end
    idle();
    chk("drain_outstanding", outstanding, 0);
    chk("drain_count", lat_count, 32);
    chk("drain_total", lat_total, 1024);
    chk("drain_min", lat_min, 1);
    chk("drain_max", lat_max, 63);
    chk("drain_dup", err_dup_id, 0);
    chk("drain_orphan", err_orphan, 0);

    // Orphan rlast, then clear.
    do_clear();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    idle();
    chk("orph_flag", err_orphan, 1);
    chk("orph_lat_valid", lat_valid, 0);
    chk("orph_count", lat_count, 0);
    do_clear();
    chk("orph_clr_flag", err_orphan, 0);
    chk("orph_clr_min", lat_min, ONES32);

    // Same-cycle retire and re-open of ID 2.
    do_clear();
    drive(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0);
    tick();
    chk("same_lat_valid", lat_valid, 1);
    chk("same_lat_value", lat_value, 1);
    chk("same_outstanding", outstanding, 1);
    chk("same_dup", err_dup_id, 0);
    drive(1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
    tick();
    idle();
    chk("reopen_lat_valid", lat_valid, 1);
    chk("reopen_lat_value", lat_value, 1);
    chk("reopen_outstanding", outstanding, 0);
    chk("reopen_count", lat_count, 2);
    chk("reopen_orphan", err_orphan, 0);

    // Timestamp wrap.
    do_clear();
    force dut.ts_q = 32'hFFFF_FFF0;
    release dut.ts_q;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    repeat (31) tick();
    drive(1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    idle();
    chk("wrap_lat_valid", lat_valid, 1);
    chk("wrap_lat_value", lat_value, 32'h20);

    // Total saturation.
    do_clear();
    force dut.total_q = 48'hFFFF_FFFF_FFD0;
    release dut.total_q;
    drive(1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    repeat (99) tick();
    drive(1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    idle();
    chk("sat_lat_value", lat_value, 100);
    chk("sat_total", lat_total, 48'hFFFF_FFFF_FFFF);
    chk("sat_count", lat_count, 1);

    // Reset mid-transaction discards open entries.
    do_clear();
    drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    chk("midrst_open", outstanding, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    idle();
    chk("midrst_orphan", err_orphan, 1);
    chk("midrst_lat_valid", lat_valid, 0);
    chk("midrst_outstanding", outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
